// File: rtl/cp0_pkg.sv
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared CP0 register indices, field positions and ExcCodes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

  typedef enum logic [4:0] {
    REG_BADVADDR = 5'd8,
    REG_SR       = 5'd12,
    REG_CAUSE    = 5'd13,
    REG_EPC      = 5'd14,
    REG_PRID     = 5'd15
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int SR_IE         = 0;
  localparam int SR_EXL        = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

endpackage

`default_nettype wire

// File: rtl/cp0_irq_pending.sv
// ============================================================================
//  Module      : cp0_irq_pending
//  Description : Per-line edge detect with sticky pending bits; level lines
//                pass straight through to the effective pending vector.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_irq_pending
  import cp0_pkg::*;
#(
  parameter int         NUM_HWINT = 6,
  parameter logic [5:0] EDGE_MASK = 6'b000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 clr_en,
  input  logic [NUM_HWINT-1:0] clr_keep,
  output logic [NUM_HWINT-1:0] ip
);

  localparam logic [NUM_HWINT-1:0] EDGE = EDGE_MASK[NUM_HWINT-1:0];

  logic [NUM_HWINT-1:0] pend_q, pend_d;
  logic [NUM_HWINT-1:0] prev_q, prev_d;
  logic [NUM_HWINT-1:0] clr_mask;

  // A fresh rising edge outranks a software clear in the same cycle.
  always_comb begin
    clr_mask = clr_en ? ~clr_keep : '0;
    pend_d   = (hwint & ~prev_q) | (pend_q & ~clr_mask);
    prev_d   = hwint;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      prev_q <= '0;
    end else begin
      pend_q <= pend_d;
      prev_q <= prev_d;
    end
  end

  assign ip = (EDGE & pend_q) | (~EDGE & hwint);

endmodule

`default_nettype wire

// File: rtl/cp0_ctrl_param.sv
// ============================================================================
//  Module      : cp0_ctrl_param
//  Description : MEM-stage coprocessor 0 (SR, Cause, EPC, PRId) with
//                exception/interrupt arbitration. Optional BadVAddr register
//                is built when CP0_BADVADDR_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_ctrl_param
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [5:0]  EDGE_MASK = 6'b000000,
  parameter logic [31:0] PRID_VAL  = 32'h0000_0700
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ra,
  input  logic [4:0]           wa,
  input  logic                 we,
  input  logic [31:0]          wd,
  input  logic [31:0]          pc,
  input  logic                 bd,
  input  logic [4:0]           exc_code_in,
  input  logic                 eret,
  input  logic [NUM_HWINT-1:0] hwint,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0]          bad_vaddr,
`endif
  output logic                 int_req,
  output logic [31:0]          epc_out,
  output logic [31:0]          rd,
  output logic                 exl_out
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [NUM_HWINT-1:0] im_q, im_d;
  logic                 exl_q, exl_d;
  logic                 ie_q, ie_d;
  logic                 bd_q, bd_d;
  logic [4:0]           code_q, code_d;
  logic [31:0]          epc_q, epc_d;

  logic [NUM_HWINT-1:0] ip;
  logic                 irq;
  logic                 exc;
  logic                 wr_ok;
  logic [31:0]          restart_pc;

  assign irq        = (|(ip & im_q)) & ie_q & ~exl_q;
  assign exc        = (exc_code_in != EXC_INT) & ~exl_q;
  assign int_req    = irq | exc;
  assign wr_ok      = we & ~int_req;
  assign restart_pc = bd ? (pc - 32'd4) : pc;

  cp0_irq_pending #(
    .NUM_HWINT (NUM_HWINT),
    .EDGE_MASK (EDGE_MASK)
  ) u_pending (
    .clk      (clk),
    .reset    (reset),
    .hwint    (hwint),
    .clr_en   (wr_ok & (wa == REG_CAUSE)),
    .clr_keep (wd[CAUSE_IP_LSB +: NUM_HWINT]),
    .ip       (ip)
  );

  // Exception entry outranks both mtc0 and eret; eret outranks an SR.EXL write.
  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    code_d = code_q;
    epc_d  = epc_q;
    if (int_req) begin
      exl_d  = 1'b1;
      code_d = irq ? EXC_INT : exc_code_in;
      bd_d   = bd;
      epc_d  = restart_pc & WORD_MASK;
    end else begin
      if (we && (wa == REG_SR)) begin
        im_d  = wd[SR_IM_LSB +: NUM_HWINT];
        exl_d = wd[SR_EXL];
        ie_d  = wd[SR_IE];
      end
      if (we && (wa == REG_EPC)) begin
        epc_d = wd & WORD_MASK;
      end
      if (eret) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_q, badvaddr_d;

  always_comb begin
    badvaddr_d = badvaddr_q;
    if (exc && !irq && ((exc_code_in == EXC_ADEL) || (exc_code_in == EXC_ADES))) begin
      badvaddr_d = bad_vaddr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      badvaddr_q <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
    end
  end
`endif

  // Read port shows state before this cycle's write.
  always_comb begin
    rd = '0;
    case (ra)
      REG_SR: begin
        rd[SR_IM_LSB +: NUM_HWINT] = im_q;
        rd[SR_EXL]                 = exl_q;
        rd[SR_IE]                  = ie_q;
      end
      REG_CAUSE: begin
        rd[CAUSE_BD]                  = bd_q;
        rd[CAUSE_IP_LSB +: NUM_HWINT] = ip;
        rd[CAUSE_EXC_LSB +: 5]        = code_q;
      end
      REG_EPC:  rd = epc_q;
      REG_PRID: rd = PRID_VAL;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: rd = badvaddr_q;
`endif
      default: rd = '0;
    endcase
  end

  assign epc_out = epc_q;
  assign exl_out = exl_q;

endmodule

`default_nettype wire

// File: tb/tb_cp0_ctrl_param.sv
// ============================================================================
//  Module      : tb_cp0_ctrl_param
//  Description : Scoreboard bench for cp0_ctrl_param with a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cp0_ctrl_param;

  localparam int          N    = 6;
  localparam logic [5:0]  EM   = 6'b001010;
  localparam logic [31:0] PRID = 32'h0000_0700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [4:0]    ra, wa;
  logic          we;
  logic [31:0]   wd, pc;
  logic          bd;
  logic [4:0]    exc_code_in;
  logic          eret;
  logic [N-1:0]  hwint;
`ifdef CP0_BADVADDR_EN
  logic [31:0]   bad_vaddr;
`endif
  logic          int_req;
  logic [31:0]   epc_out, rd;
  logic          exl_out;

  cp0_ctrl_param #(
    .NUM_HWINT (N),
    .EDGE_MASK (EM),
    .PRID_VAL  (PRID)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ra          (ra),
    .wa          (wa),
    .we          (we),
    .wd          (wd),
    .pc          (pc),
    .bd          (bd),
    .exc_code_in (exc_code_in),
    .eret        (eret),
    .hwint       (hwint),
`ifdef CP0_BADVADDR_EN
    .bad_vaddr   (bad_vaddr),
`endif
    .int_req     (int_req),
    .epc_out     (epc_out),
    .rd          (rd),
    .exl_out     (exl_out)
  );

  typedef struct {
    logic        ir;
    logic [31:0] rdv;
    logic [31:0] epc;
    logic        exl;
    logic [4:0]  ra_s;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference state, kept as the architectural registers themselves.
  logic [N-1:0] m_im, m_pend, m_prev;
  logic         m_ie, m_exl, m_bd;
  logic [4:0]   m_code;
  logic [31:0]  m_epc;
  logic [31:0]  m_bva;

  function automatic logic [N-1:0] model_ip();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = EM[i] ? m_pend[i] : hwint[i];
    return v;
  endfunction

  function automatic logic model_irq();
    logic [N-1:0] v;
    logic any;
    v   = model_ip();
    any = 1'b0;
    for (int i = 0; i < N; i++) if (v[i] && m_im[i]) any = 1'b1;
    return any && m_ie && !m_exl;
  endfunction

  function automatic logic model_exc();
    return (exc_code_in != 5'd0) && !m_exl;
  endfunction

  function automatic logic [31:0] model_rd();
    case (ra)
      5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(model_ip()) << 10) | (32'(m_code) << 2);
      5'd14:   return m_epc;
      5'd15:   return PRID;
`ifdef CP0_BADVADDR_EN
      5'd8:    return m_bva;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    m_im = '0; m_pend = '0; m_prev = '0;
    m_ie = 1'b0; m_exl = 1'b0; m_bd = 1'b0;
    m_code = '0; m_epc = '0; m_bva = '0;
  endtask

  task automatic model_step();
    logic irq, req;
    irq = model_irq();
    req = irq || model_exc();
    for (int i = 0; i < N; i++) begin
      logic rise, clr;
      rise = hwint[i] && !m_prev[i];
      clr  = we && !req && (wa == 5'd13) && !wd[10+i];
      m_pend[i] = rise || (m_pend[i] && !clr);
    end
    m_prev = hwint;
    if (req) begin
      m_exl  = 1'b1;
      m_code = irq ? 5'd0 : exc_code_in;
      m_bd   = bd;
      m_epc  = (bd ? pc - 32'd4 : pc) & ~32'd3;
`ifdef CP0_BADVADDR_EN
      if (!irq && (exc_code_in == 5'd4 || exc_code_in == 5'd5)) m_bva = bad_vaddr;
`endif
    end else begin
      if (we && wa == 5'd12) begin
        m_im  = wd[10 +: N];
        m_exl = wd[1];
        m_ie  = wd[0];
      end
      if (we && wa == 5'd14) m_epc = wd & ~32'd3;
      if (eret) m_exl = 1'b0;
    end
  endtask

  // Push the expectation for the current inputs, then advance one clock.
  task automatic cycle();
    exp_t e;
    if (!reset) model_clear();
    e.ir   = model_irq() || model_exc();
    e.rdv  = model_rd();
    e.epc  = m_epc;
    e.exl  = m_exl;
    e.ra_s = ra;
    q.push_back(e);
    @(posedge clk);
    if (!reset) model_clear();
    else model_step();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; eret = 1'b0; exc_code_in = 5'd0; bd = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want,
                       input logic [4:0] ra_s);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s (ra=%0d t=%0t): got %h want %h", nm, ra_s, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("int_req", 32'(int_req), 32'(e.ir), e.ra_s);
      check("rd", rd, e.rdv, e.ra_s);
      check("epc_out", epc_out, e.epc, e.ra_s);
      check("exl_out", 32'(exl_out), 32'(e.exl), e.ra_s);
    end
  end

  initial begin
    reset = 1'b0; ra = 5'd12; wa = 5'd0; wd = '0; pc = 32'h3000; hwint = '0;
`ifdef CP0_BADVADDR_EN
    bad_vaddr = '0;
`endif
    idle();
    @(posedge clk); #1;
    cycle(); ra = 5'd15; cycle();
    reset = 1'b1;

    // Post-reset register contents
    for (int r = 12; r <= 15; r++) begin ra = 5'(r); cycle(); end

    // Level interrupt on line 0
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001; pc = 32'h3010; ra = 5'd13; cycle();
    hwint = '0; ra = 5'd14; cycle();
    ra = 5'd13; cycle();
    eret = 1'b1; ra = 5'd12; cycle(); eret = 1'b0;
    mtc0(5'd12, 32'h0);

    // Edge line 1: sticky pending, then software clear
    hwint = 6'b000010; cycle();
    hwint = '0; ra = 5'd13; cycle(); cycle();
    mtc0(5'd12, 32'h0000_0801);
    pc = 32'h3100; cycle();
    mtc0(5'd13, 32'h0);
    ra = 5'd13; cycle();
    eret = 1'b1; cycle(); eret = 1'b0;
    mtc0(5'd12, 32'h0);

    // Exception in a delay slot; concurrent mtc0 to EPC is dropped
    exc_code_in = 5'd12; bd = 1'b1; pc = 32'h3024;
    we = 1'b1; wa = 5'd14; wd = 32'hDEAD_0000; cycle(); idle();
    ra = 5'd14; cycle(); ra = 5'd13; cycle();
    eret = 1'b1; cycle(); eret = 1'b0;

    // pc-4 wrap at address zero
    exc_code_in = 5'd10; bd = 1'b1; pc = 32'h0; cycle(); idle();
    ra = 5'd14; cycle();
    eret = 1'b1; cycle(); eret = 1'b0;

    // Interrupt beats a simultaneous exception
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000001; exc_code_in = 5'd10; pc = 32'h3200; cycle(); idle();
    hwint = '0; ra = 5'd13; cycle();
    eret = 1'b1; cycle(); eret = 1'b0;
    ra = 5'd12; cycle();

    // Asynchronous reset while in the handler
    exc_code_in = 5'd12; cycle(); idle();
    reset = 1'b0; cycle();
    reset = 1'b1; cycle();

`ifdef CP0_BADVADDR_EN
    exc_code_in = 5'd4; bad_vaddr = 32'h0000_7F01; cycle(); idle();
    ra = 5'd8; cycle();
    eret = 1'b1; cycle(); eret = 1'b0;
`endif

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] ra_pick[6];
      ra_pick = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'($urandom)};
      ra = ra_pick[$urandom_range(0, 5)];
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) hwint[i] = ~hwint[i];
      we = ($urandom_range(0, 3) == 0);
      wa = ra_pick[$urandom_range(0, 5)];
      wd = $urandom;
      pc = $urandom;
      bd = 1'($urandom);
      case ($urandom_range(0, 19))
        0:       exc_code_in = 5'd4;
        1:       exc_code_in = 5'd5;
        2:       exc_code_in = 5'd10;
        3:       exc_code_in = 5'd12;
        default: exc_code_in = 5'd0;
      endcase
      eret  = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 299) != 0);
`ifdef CP0_BADVADDR_EN
      bad_vaddr = $urandom;
`endif
      cycle();
    end
    reset = 1'b1; idle(); cycle();

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
